// File: rtl/bar_decay_if.sv
// Bin sample bus from the spectrum stage into bar_decay: one qualified
// (index, magnitude) pair per cycle, no backpressure.
interface bar_decay_if;
  logic        bin_valid;
  logic [3:0]  bin_idx;
  logic [17:0] bin_mag;

  modport master (output bin_valid, bin_idx, bin_mag);
  modport slave  (input  bin_valid, bin_idx, bin_mag);
endinterface

// File: rtl/bar_decay.sv
// Spectrum bar peak-hold with per-frame decay: shadows collect the frame
// maximum per bin, and a 16-cycle sweep inside vsync folds them into the bars.
module bar_decay #(
  parameter int unsigned DECAY = 512,
  parameter int unsigned CLIP  = 245760
) (
  input  logic          vgaclk,
  input  logic          rst,
  input  logic          vsync,
  bar_decay_if.slave    bin,
  output logic [17:0]   bar0,
  output logic [17:0]   bar1,
  output logic [17:0]   bar2,
  output logic [17:0]   bar3,
  output logic [17:0]   bar4,
  output logic [17:0]   bar5,
  output logic [17:0]   bar6,
  output logic [17:0]   bar7,
  output logic [17:0]   bar8,
  output logic [17:0]   bar9,
  output logic [17:0]   bar10,
  output logic [17:0]   bar11,
  output logic [17:0]   bar12,
  output logic [17:0]   bar13,
  output logic [17:0]   bar14,
  output logic [17:0]   bar15,
  output logic          update_busy,
  output logic          frame_tick
);

  localparam logic [17:0] DECAY_V = 18'(DECAY);
  localparam logic [17:0] CLIP_V  = 18'(CLIP);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t      state;
  logic [3:0]  sidx;
  logic        vsync_d;
  logic [17:0] shadow [16];
  logic [17:0] bar    [16];

  logic [17:0] mag_c;
  logic [17:0] merged;
  logic [17:0] decayed;
  logic [17:0] swept;
  logic        frame_evt;

  // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    mag_c     = (bin.bin_mag > CLIP_V) ? CLIP_V : bin.bin_mag;
    merged    = (shadow[bin.bin_idx] > mag_c) ? shadow[bin.bin_idx] : mag_c;
    decayed   = (bar[sidx] >= DECAY_V) ? (bar[sidx] - DECAY_V) : '0;
    swept     = (shadow[sidx] > decayed) ? shadow[sidx] : decayed;
    frame_evt = vsync_d & ~vsync;
  end

  // NOTE: all state updates use <= so every read in this block sees pre-edge values.
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      state       <= IDLE;
      sidx        <= '0;
      vsync_d     <= 1'b0;
      update_busy <= 1'b0;
      frame_tick  <= 1'b0;
      // NOTE: the 16-entry arrays are flops, not RAM, so resetting them is cheap and aborts any sweep cleanly.
      for (int i = 0; i < 16; i++) begin
        shadow[i] <= '0;
        bar[i]    <= '0;
      end
    end else begin
      vsync_d    <= vsync;
      frame_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bin.bin_valid) shadow[bin.bin_idx] <= merged;
          if (frame_evt) begin
            state       <= UPDATE;
            sidx        <= '0;
            update_busy <= 1'b1;
          end
        end
        UPDATE: begin
          bar[sidx]    <= swept;
          shadow[sidx] <= '0;
          // A sample for the slot being swept right now starts the next frame's maximum.
          if (bin.bin_valid)
            shadow[bin.bin_idx] <= (bin.bin_idx == sidx) ? mag_c : merged;
          sidx <= sidx + 4'd1;
          if (sidx == 4'd15) begin
            state       <= IDLE;
            update_busy <= 1'b0;
            frame_tick  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bar0  = bar[0];
  assign bar1  = bar[1];
  assign bar2  = bar[2];
  assign bar3  = bar[3];
  assign bar4  = bar[4];
  assign bar5  = bar[5];
  assign bar6  = bar[6];
  assign bar7  = bar[7];
  assign bar8  = bar[8];
  assign bar9  = bar[9];
  assign bar10 = bar[10];
  assign bar11 = bar[11];
  assign bar12 = bar[12];
  assign bar13 = bar[13];
  assign bar14 = bar[14];
  assign bar15 = bar[15];

endmodule

// File: tb/tb_bar_decay.sv
// Scoreboard bench for bar_decay: expected bar values are queued as samples
// are sent and popped against the bars when each sweep's frame_tick appears.
module tb_bar_decay;

  logic        vgaclk = 1'b0;
  logic        rst;
  logic        vsync;
  logic [17:0] bars [16];
  logic        update_busy;
  logic        frame_tick;

  bar_decay_if bin ();

  always #5 vgaclk = ~vgaclk;

  bar_decay dut (
    .vgaclk      (vgaclk),
    .rst         (rst),
    .vsync       (vsync),
    .bin         (bin),
    .bar0        (bars[0]),
    .bar1        (bars[1]),
    .bar2        (bars[2]),
    .bar3        (bars[3]),
    .bar4        (bars[4]),
    .bar5        (bars[5]),
    .bar6        (bars[6]),
    .bar7        (bars[7]),
    .bar8        (bars[8]),
    .bar9        (bars[9]),
    .bar10       (bars[10]),
    .bar11       (bars[11]),
    .bar12       (bars[12]),
    .bar13       (bars[13]),
    .bar14       (bars[14]),
    .bar15       (bars[15]),
    .update_busy (update_busy),
    .frame_tick  (frame_tick)
  );

  typedef struct {
    string       name;
    int          idx;
    logic [17:0] val;
  } exp_t;

  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push_exp(input string name, input int idx, input logic [17:0] val);
    exp_t e;
    e.name = name;
    e.idx  = idx;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (bars[e.idx] !== e.val) begin
        n_err++;
        $display("FAIL %s bar%0d: got %0d, expected %0d", e.name, e.idx, bars[e.idx], e.val);
      end
    end
  endtask

  // All stimulus tasks start and end just after a falling edge.
  task automatic send(input int idx, input int mag);
    bin.bin_valid = 1'b1;
    bin.bin_idx   = 4'(idx);
    bin.bin_mag   = 18'(mag);
    @(negedge vgaclk);
    bin.bin_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vsync = 1'b1;
    bin.bin_valid = 1'b0;
    repeat (2) @(negedge vgaclk);
    rst = 1'b0;
    sb.delete();
  endtask

  // One frame: vsync 1->0, optional sample injected while sidx == inj_k,
  // optional vsync glitch starting at sidx == glitch_k, optional latency watch.
  task automatic frame(input string name, input int inj_k, input int inj_idx,
                       input int inj_mag, input int glitch_k,
                       input int watch_idx, input logic [17:0] watch_val);
    int tick_k = -1;
    int chg_k  = -1;
    vsync = 1'b1;
    @(negedge vgaclk);
    vsync = 1'b0;
    @(negedge vgaclk);
    n_vec++;
    if (update_busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_after_event: got %b, expected 1", name, update_busy);
    end
    for (int k = 1; k <= 40 && tick_k < 0; k++) begin
      if (k - 1 == inj_k) begin
        bin.bin_valid = 1'b1;
        bin.bin_idx   = 4'(inj_idx);
        bin.bin_mag   = 18'(inj_mag);
      end
      if (k - 1 == glitch_k)     vsync = 1'b1;
      if (k - 1 == glitch_k + 1) vsync = 1'b0;
      @(negedge vgaclk);
      bin.bin_valid = 1'b0;
      if (watch_idx >= 0 && chg_k < 0 && bars[watch_idx] === watch_val) chg_k = k;
      if (frame_tick === 1'b1) tick_k = k;
    end
    n_vec++;
    if (tick_k != 16) begin
      n_err++;
      $display("FAIL %s tick_latency: got %0d, expected 16", name, tick_k);
    end
    if (watch_idx >= 0) begin
      n_vec++;
      if (chg_k != watch_idx + 1) begin
        n_err++;
        $display("FAIL %s bar%0d_latency: got %0d, expected %0d", name, watch_idx, chg_k, watch_idx + 1);
      end
    end
    n_vec++;
    if (update_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_at_tick: got %b, expected 0", name, update_busy);
    end
    score();
    @(negedge vgaclk);
    n_vec++;
    if (frame_tick !== 1'b0 || update_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_tick: got tick=%b busy=%b, expected 0 0", name, frame_tick, update_busy);
    end
  endtask

  task automatic test_reset();
    bit saw_busy = 1'b0;
    rst = 1'b1;
    vsync = 1'b0;
    bin.bin_valid = 1'b0;
    bin.bin_idx = '0;
    bin.bin_mag = '0;
    repeat (2) @(negedge vgaclk);
    n_vec++;
    if (update_busy !== 1'b0 || frame_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got busy=%b tick=%b, expected 0 0", update_busy, frame_tick);
    end
    for (int i = 0; i < 16; i++) push_exp("reset", i, 18'd0);
    score();
    rst = 1'b0;
    repeat (6) begin
      @(negedge vgaclk);
      if (update_busy !== 1'b0) saw_busy = 1'b1;
    end
    n_vec++;
    if (saw_busy) begin
      n_err++;
      $display("FAIL reset_release_low_vsync: got busy=1, expected 0");
    end
    vsync = 1'b1;
    @(negedge vgaclk);
  endtask

  task automatic test_single_bin();
    do_reset();
    send(3, 100000);
    for (int i = 0; i < 16; i++) push_exp("single", i, (i == 3) ? 18'd100000 : 18'd0);
    frame("single", -1, 0, 0, -1, 3, 18'd100000);
  endtask

  task automatic test_decay();
    do_reset();
    send(5, 1000);
    push_exp("decay_load", 5, 18'd1000);
    frame("decay_load", -1, 0, 0, -1, -1, 18'd0);
    push_exp("decay_1", 5, 18'd488);
    frame("decay_1", -1, 0, 0, -1, -1, 18'd0);
    push_exp("decay_2", 5, 18'd0);
    frame("decay_2", -1, 0, 0, -1, -1, 18'd0);
    push_exp("decay_3", 5, 18'd0);
    frame("decay_3", -1, 0, 0, -1, -1, 18'd0);
  endtask

  task automatic test_merge();
    do_reset();
    send(7, 160000);
    push_exp("merge_load", 7, 18'd160000);
    frame("merge_load", -1, 0, 0, -1, -1, 18'd0);
    send(7, 200000);
    send(7, 150000);
    push_exp("merge_max", 7, 18'd200000);
    frame("merge_max", -1, 0, 0, -1, -1, 18'd0);
    push_exp("merge_decay", 7, 18'd199488);
    frame("merge_decay", -1, 0, 0, -1, -1, 18'd0);
  endtask

  task automatic test_clip();
    do_reset();
    send(2, 262143);
    send(9, 245760);
    send(11, 245761);
    send(12, 245759);
    push_exp("clip_max", 2, 18'd245760);
    push_exp("clip_eq", 9, 18'd245760);
    push_exp("clip_over", 11, 18'd245760);
    push_exp("clip_under", 12, 18'd245759);
    frame("clip", -1, 0, 0, -1, -1, 18'd0);
  endtask

  task automatic test_collision();
    do_reset();
    push_exp("coll_same", 4, 18'd0);
    frame("coll_same", 4, 4, 5000, -1, -1, 18'd0);
    push_exp("coll_carry", 4, 18'd5000);
    push_exp("coll_ahead", 10, 18'd7000);
    frame("coll_ahead", 4, 10, 7000, -1, -1, 18'd0);
    // Sample behind the sweep plus a vsync glitch mid-sweep that must be ignored.
    push_exp("coll_behind", 1, 18'd0);
    push_exp("coll_behind", 4, 18'd4488);
    push_exp("coll_behind", 10, 18'd6488);
    frame("coll_behind", 5, 1, 3000, 8, -1, 18'd0);
    push_exp("coll_next", 1, 18'd3000);
    push_exp("coll_next", 4, 18'd3976);
    push_exp("coll_next", 10, 18'd5976);
    frame("coll_next", -1, 0, 0, -1, -1, 18'd0);
  endtask

  task automatic test_reset_mid_sweep();
    bit saw_busy = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) send(i, 1000 * (i + 1));
    for (int i = 0; i < 16; i++) push_exp("mid_load", i, 18'(1000 * (i + 1)));
    frame("mid_load", -1, 0, 0, -1, -1, 18'd0);
    send(6, 50000);
    vsync = 1'b1;
    @(negedge vgaclk);
    vsync = 1'b0;
    @(negedge vgaclk);
    repeat (8) @(negedge vgaclk);
    rst = 1'b1;
    @(negedge vgaclk);
    rst = 1'b0;
    n_vec++;
    if (update_busy !== 1'b0 || frame_tick !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_ctrl: got busy=%b tick=%b, expected 0 0", update_busy, frame_tick);
    end
    for (int i = 0; i < 16; i++) push_exp("mid_reset", i, 18'd0);
    score();
    repeat (20) begin
      @(negedge vgaclk);
      if (update_busy !== 1'b0 || frame_tick !== 1'b0) saw_busy = 1'b1;
    end
    n_vec++;
    if (saw_busy) begin
      n_err++;
      $display("FAIL mid_reset_no_sweep: got sweep activity, expected none");
    end
    for (int i = 0; i < 16; i++) push_exp("post_reset", i, 18'd0);
    frame("post_reset", -1, 0, 0, -1, -1, 18'd0);
  endtask

  initial begin
    test_reset();
    test_single_bin();
    test_decay();
    test_merge();
    test_clip();
    test_collision();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
